answer_checker: RTL and testbench

Judges the player's response to each not-not round. It accepts a challenge (the 4-bit mask of acceptable keys) from the round generator over a valid/ready handshake. It then synchronises and edge-detects the push buttons and decides correct or wrong within a bounded response window. It also keeps score and high score. It is the consuming end of the challenge path: the generator and display produce a round, and this block reads the player's answer and requests the next round.

---
 rtl/answer_checker.sv | 153 +++++++++++++++
 tb/tb_answer_checker.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/answer_checker.sv
// Judges each not-not round: takes a key mask over valid/ready, watches debounced-free
// button edges inside a response window, pulses correct/wrong, and keeps score.
// Optional: define ANSWER_CHECKER_HIGHSCORE_EN to build the high-score register.
module answer_checker #(
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       round_valid,
    input  logic [3:0] expected,
    input  logic [3:0] KEY,
    output logic       round_ready,
    output logic       correct,
    output logic       wrong,
    output logic       playing,
    output logic       lose,
    output logic [7:0] score,
    output logic [7:0] highscore
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_STOP,
        S_IDLE,
        S_WAIT,
        S_LOSE
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    mask_q, mask_d;
    logic [7:0]    score_q, score_d;
    logic          correct_q, correct_d;
    logic          wrong_q, wrong_d;

    logic [3:0]    key_sync1_q, key_sync2_q, pressed_prev_q;
    logic [3:0]    pressed, press_set;
    logic          press_evt;

    // Buttons are active-low and asynchronous; only fresh presses count, held keys never re-fire.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_sync1_q    <= 4'b1111;
            key_sync2_q    <= 4'b1111;
            pressed_prev_q <= 4'b0000;
        end else begin
            key_sync1_q    <= KEY;
            key_sync2_q    <= key_sync1_q;
            pressed_prev_q <= pressed;
        end
    end

    assign pressed   = ~key_sync2_q;
    assign press_set = pressed & ~pressed_prev_q;
    assign press_evt = |press_set;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_STOP;
            timer_q   <= '0;
            mask_q    <= 4'b0000;
            score_q   <= 8'd0;
            correct_q <= 1'b0;
            wrong_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            mask_q    <= mask_d;
            score_q   <= score_d;
            correct_q <= correct_d;
            wrong_q   <= wrong_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        mask_d    = mask_q;
        score_d   = score_q;
        correct_d = 1'b0;
        wrong_d   = 1'b0;

        case (state_q)
            S_STOP, S_LOSE: begin
                if (start) begin
                    state_d = S_IDLE;
                    score_d = 8'd0;
                end
            end
            S_IDLE: begin
                if (round_valid) begin
                    mask_d  = expected;
                    timer_d = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                timer_d = timer_q + TW'(1);
                // A press on the last window cycle takes priority over the timeout verdict.
                if (press_evt) begin
                    if ((press_set & ~mask_q) == 4'b0000) begin
                        correct_d = 1'b1;
                    end else begin
                        wrong_d = 1'b1;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    if (mask_q == 4'b0000) begin
                        correct_d = 1'b1;
                    end else begin
                        wrong_d = 1'b1;
                    end
                end

                if (correct_d) begin
                    score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                    state_d = S_IDLE;
                end else if (wrong_d) begin
                    state_d = S_LOSE;
                end
            end
            default: begin
                state_d = S_STOP;
            end
        endcase
    end

`ifdef ANSWER_CHECKER_HIGHSCORE_EN
    logic [7:0] highscore_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            highscore_q <= 8'd0;
        end else if (wrong_d && (score_q > highscore_q)) begin
            highscore_q <= score_q;
        end
    end

    assign highscore = highscore_q;
`else
    assign highscore = 8'd0;
`endif

    assign round_ready = (state_q == S_IDLE);
    assign playing     = (state_q == S_IDLE) || (state_q == S_WAIT);
    assign lose        = (state_q == S_LOSE);
    assign correct     = correct_q;
    assign wrong       = wrong_q;
    assign score       = score_q;

endmodule

// File: tb/tb_answer_checker.sv
// Self-checking bench for answer_checker: directed rounds followed by randomized rounds,
// each judged by a round-level model of the scoring rules.
module tb_answer_checker;

    localparam int T = 16;

`ifdef ANSWER_CHECKER_HIGHSCORE_EN
    localparam bit HS_EN = 1'b1;
`else
    localparam bit HS_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       round_valid;
    logic [3:0] expected;
    logic [3:0] KEY;
    logic       round_ready;
    logic       correct;
    logic       wrong;
    logic       playing;
    logic       lose;
    logic [7:0] score;
    logic [7:0] highscore;

    int nChecks = 0;
    int nErrors = 0;

    logic       expReady;
    logic       expPlaying;
    logic       expLose;
    logic [7:0] expScore;
    logic [7:0] expHigh;

    logic [3:0] m;
    logic [3:0] k;
    int         d;

    always #5 clock = ~clock;

    answer_checker #(.TIMEOUT_CYCLES(T)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .round_valid (round_valid),
        .expected    (expected),
        .KEY         (KEY),
        .round_ready (round_ready),
        .correct     (correct),
        .wrong       (wrong),
        .playing     (playing),
        .lose        (lose),
        .score       (score),
        .highscore   (highscore)
    );

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] required);
        nChecks++;
        assert (observed === required) else begin
            nErrors++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, required);
        end
    endtask

    task automatic checkOutput(input string tag, input logic expCorrect, input logic expWrong);
        check({tag, ".round_ready"}, {7'd0, round_ready}, {7'd0, expReady});
        check({tag, ".correct"},     {7'd0, correct},     {7'd0, expCorrect});
        check({tag, ".wrong"},       {7'd0, wrong},       {7'd0, expWrong});
        check({tag, ".playing"},     {7'd0, playing},     {7'd0, expPlaying});
        check({tag, ".lose"},        {7'd0, lose},        {7'd0, expLose});
        check({tag, ".score"},       score,               expScore);
        check({tag, ".highscore"},   highscore,           expHigh);
    endtask

    task automatic applyStimulus(input logic s, input logic v, input logic [3:0] e, input logic [3:0] keys);
        start       = s;
        round_valid = v;
        expected    = e;
        KEY         = keys;
    endtask

    task automatic cyc();
        @(negedge clock);
    endtask

    task automatic modelReset();
        expReady   = 1'b0;
        expPlaying = 1'b0;
        expLose    = 1'b0;
        expScore   = 8'd0;
        expHigh    = 8'd0;
    endtask

    task automatic modelJudge(input bit ok);
        if (ok) begin
            expScore   = (expScore == 8'd255) ? 8'd255 : expScore + 8'd1;
            expReady   = 1'b1;
            expPlaying = 1'b1;
            expLose    = 1'b0;
        end else begin
            if (HS_EN && (expScore > expHigh)) expHigh = expScore;
            expReady   = 1'b0;
            expPlaying = 1'b0;
            expLose    = 1'b1;
        end
    endtask

    task automatic startGame();
        applyStimulus(1'b1, 1'b0, 4'h0, 4'hF);
        cyc();
        applyStimulus(1'b0, 1'b0, 4'h0, 4'hF);
        expScore   = 8'd0;
        expReady   = 1'b1;
        expPlaying = 1'b1;
        expLose    = 1'b0;
        checkOutput("start", 1'b0, 1'b0);
    endtask

    // Offer one challenge; keys are pressed d cycles into the window (keys==0 means no press).
    // With held, the same keys are already down before the handshake and get released then re-pressed.
    task automatic playRound(input logic [3:0] mask, input logic [3:0] keys, input int dly, input bit held);
        bit pressCounts;
        int jo;
        bit ok;
        pressCounts = (keys != 4'h0) && (dly + 3 <= T);
        jo          = pressCounts ? dly + 3 : T;
        ok          = pressCounts ? ((keys & ~mask) == 4'h0) : (mask == 4'h0);

        if (held) begin
            applyStimulus(1'b0, 1'b0, 4'h0, ~keys);
            repeat (4) begin
                cyc();
                checkOutput("held_idle", 1'b0, 1'b0);
            end
        end

        applyStimulus(1'b0, 1'b1, mask, KEY);
        cyc();
        applyStimulus(1'b0, 1'b0, 4'h0, KEY);
        expReady = 1'b0;

        for (int e = 0; e <= jo + 1; e++) begin
            if (e > 0) cyc();
            if (e == jo) begin
                modelJudge(ok);
                checkOutput("judge", ok, !ok);
            end else begin
                checkOutput("window", 1'b0, 1'b0);
            end
            if (held && (e == dly - 2)) KEY = 4'hF;
            if ((keys != 4'h0) && (e == dly)) KEY = ~keys;
        end

        KEY = 4'hF;
        repeat (3) begin
            cyc();
            checkOutput("settle", 1'b0, 1'b0);
        end
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'h0, 4'hF);
        modelReset();
        cyc();
        cyc();
        checkOutput("reset", 1'b0, 1'b0);
        reset = 1'b0;
        cyc();
        checkOutput("after_reset", 1'b0, 1'b0);

        $display("[TB] directed rounds");
        startGame();
        playRound(4'b0100, 4'b0100, 2, 1'b0);

        applyStimulus(1'b1, 1'b0, 4'h0, 4'hF);
        cyc();
        applyStimulus(1'b0, 1'b0, 4'h0, 4'hF);
        cyc();
        checkOutput("start_in_idle", 1'b0, 1'b0);

        playRound(4'b0001, 4'b1000, 1, 1'b0);
        startGame();
        playRound(4'b0000, 4'b0000, 0, 1'b0);
        playRound(4'b1111, 4'b0000, 0, 1'b0);
        startGame();
        playRound(4'b0001, 4'b0001, 5, 1'b1);
        playRound(4'b0010, 4'b0010, 13, 1'b0);
        playRound(4'b0000, 4'b0100, 13, 1'b0);

        $display("[TB] randomized rounds");
        for (int i = 0; i < 40; i++) begin
            if (expLose) startGame();
            m = 4'($urandom);
            k = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            d = $urandom_range(0, 16);
            playRound(m, k, d, 1'b0);
        end

        $display("[TB] score saturation");
        if (!expLose) playRound(4'b0001, 4'b0010, 0, 1'b0);
        startGame();
        for (int i = 0; i < 256; i++) begin
            m = 4'($urandom_range(1, 15));
            k = m & 4'($urandom);
            if (k == 4'h0) k = m;
            d = $urandom_range(0, 3);
            playRound(m, k, d, 1'b0);
        end
        check("score_saturated", score, 8'd255);

        $display("[TB] asynchronous reset inside the window");
        applyStimulus(1'b0, 1'b1, 4'h1, 4'hF);
        cyc();
        applyStimulus(1'b0, 1'b0, 4'h0, 4'hF);
        expReady = 1'b0;
        repeat (3) cyc();
        reset = 1'b1;
        #1;
        modelReset();
        checkOutput("async_reset", 1'b0, 1'b0);
        cyc();
        reset = 1'b0;
        cyc();
        checkOutput("post_reset", 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
